// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stage-control bus values and
// sequencer FSM states.
package pipeline_ctrl_pkg;

    typedef logic [1:0] ctrl_wire_bus_t;

    localparam ctrl_wire_bus_t CTRL_STATE_Default = 2'd0;
    localparam ctrl_wire_bus_t CTRL_STATE_Bubble  = 2'd1;
    localparam ctrl_wire_bus_t CTRL_STATE_Block   = 2'd2;

    localparam logic [1:0] PCTRL_RUN      = 2'd0;
    localparam logic [1:0] PCTRL_MEM_WAIT = 2'd1;
    localparam logic [1:0] PCTRL_FLUSH    = 2'd2;

    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard inputs and stage-control outputs between the core datapath
// (master) and the pipeline sequencer (slave).
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipeline_ctrl_pkg::*;

    logic [4:0]     id_rs1_addr_i;
    logic [4:0]     id_rs2_addr_i;
    logic           id_rs1_ren_i;
    logic           id_rs2_ren_i;
    logic [4:0]     ex_rd_addr_i;
    logic           ex_wreg_i;
    logic           ex_load_i;
    logic           ex_branch_taken_i;
    logic           mem_req_i;
    logic           mem_ready_i;
    logic           pc_wen_o;
    logic           redirect_o;
    ctrl_wire_bus_t ctrl_if_id_o;
    ctrl_wire_bus_t ctrl_id_ex_o;
    ctrl_wire_bus_t ctrl_ex_mem_o;
    ctrl_wire_bus_t ctrl_mem_wb_o;
    logic [CNT_W-1:0] stall_cycles_o;

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_rs1_ren_i, id_rs2_ren_i,
               ex_rd_addr_i, ex_wreg_i, ex_load_i, ex_branch_taken_i,
               mem_req_i, mem_ready_i,
        input  pc_wen_o, redirect_o, ctrl_if_id_o, ctrl_id_ex_o,
               ctrl_ex_mem_o, ctrl_mem_wb_o, stall_cycles_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_ren_i, id_rs2_ren_i,
               ex_rd_addr_i, ex_wreg_i, ex_load_i, ex_branch_taken_i,
               mem_req_i, mem_ready_i,
        output pc_wen_o, redirect_o, ctrl_if_id_o, ctrl_id_ex_o,
               ctrl_ex_mem_o, ctrl_mem_wb_o, stall_cycles_o
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: an EX load whose rd feeds a source read by the ID
// instruction. Kept standalone so the forwarding unit can reuse it.
module hazard_detect (
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs1_ren_i,
    input  logic       id_rs2_ren_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       ex_wreg_i,
    input  logic       ex_load_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit    = id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i);
    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use_o = ex_load_i && ex_wreg_i && (ex_rd_addr_i != 5'd0)
                        && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: Mealy stage control for load-use stalls, redirect
// flush tails and multi-cycle memory freezes, plus a saturating stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   bus
);

    logic [1:0]             state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic                   load_use;
    logic                   mem_stall;
    logic                   pc_wen;

    hazard_detect u_hazard_detect (
        .id_rs1_addr_i (bus.id_rs1_addr_i),
        .id_rs2_addr_i (bus.id_rs2_addr_i),
        .id_rs1_ren_i  (bus.id_rs1_ren_i),
        .id_rs2_ren_i  (bus.id_rs2_ren_i),
        .ex_rd_addr_i  (bus.ex_rd_addr_i),
        .ex_wreg_i     (bus.ex_wreg_i),
        .ex_load_i     (bus.ex_load_i),
        .load_use_o    (load_use)
    );

    // A ready in the same cycle as the request completes it without a stall.
    assign mem_stall = !bus.mem_ready_i &&
                       ((state_q == PCTRL_MEM_WAIT) || bus.mem_req_i);

    always_comb begin
        state_d           = state_q;
        flush_cnt_d       = flush_cnt_q;
        pc_wen            = 1'b1;
        bus.redirect_o    = 1'b0;
        bus.ctrl_if_id_o  = CTRL_STATE_Default;
        bus.ctrl_id_ex_o  = CTRL_STATE_Default;
        bus.ctrl_ex_mem_o = CTRL_STATE_Default;
        bus.ctrl_mem_wb_o = CTRL_STATE_Default;

        if (mem_stall) begin
            pc_wen            = 1'b0;
            bus.ctrl_if_id_o  = CTRL_STATE_Block;
            bus.ctrl_id_ex_o  = CTRL_STATE_Block;
            bus.ctrl_ex_mem_o = CTRL_STATE_Block;
            bus.ctrl_mem_wb_o = CTRL_STATE_Bubble;
            state_d           = PCTRL_MEM_WAIT;
        end else begin
            // Completion cycle behaves like RUN but resumes any pending tail.
            if (state_q == PCTRL_MEM_WAIT)
                state_d = (flush_cnt_q != '0) ? PCTRL_FLUSH : PCTRL_RUN;

            if (bus.ex_branch_taken_i) begin
                bus.redirect_o   = 1'b1;
                bus.ctrl_if_id_o = CTRL_STATE_Bubble;
                bus.ctrl_id_ex_o = CTRL_STATE_Bubble;
                flush_cnt_d      = FLUSH_CNT_W'(FLUSH_CYCLES);
                state_d          = (FLUSH_CYCLES > 0) ? PCTRL_FLUSH : PCTRL_RUN;
            end else if (state_q == PCTRL_FLUSH) begin
                bus.ctrl_if_id_o = CTRL_STATE_Bubble;
                flush_cnt_d      = (flush_cnt_q != '0) ? flush_cnt_q - 1'b1 : '0;
                if (flush_cnt_q <= FLUSH_CNT_W'(1))
                    state_d = PCTRL_RUN;
            end else if (load_use) begin
                pc_wen           = 1'b0;
                bus.ctrl_if_id_o = CTRL_STATE_Block;
                bus.ctrl_id_ex_o = CTRL_STATE_Bubble;
            end
        end

        // Reset forces a safe all-bubble pipe regardless of the flop contents.
        if (!rst) begin
            pc_wen            = 1'b0;
            bus.redirect_o    = 1'b0;
            bus.ctrl_if_id_o  = CTRL_STATE_Bubble;
            bus.ctrl_id_ex_o  = CTRL_STATE_Bubble;
            bus.ctrl_ex_mem_o = CTRL_STATE_Bubble;
            bus.ctrl_mem_wb_o = CTRL_STATE_Bubble;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_wen && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PCTRL_RUN;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_wen_o       = pc_wen;
    assign bus.stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with FLUSH_CYCLES=2 and a 4-bit stall
// counter so saturation is reachable in a few cycles.
module tb_pipeline_ctrl;

    localparam logic [1:0] D = 2'd0;
    localparam logic [1:0] U = 2'd1;
    localparam logic [1:0] K = 2'd2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipeline_ctrl_if #(.CNT_W(4)) bus ();

    pipeline_ctrl #(
        .FLUSH_CYCLES (2),
        .CNT_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] e_if, input logic [1:0] e_ie,
                            input logic [1:0] e_em, input logic [1:0] e_mw,
                            input logic e_pcw, input logic e_rdr);
        chk({tag, ".if_id"},  32'(bus.ctrl_if_id_o),  32'(e_if));
        chk({tag, ".id_ex"},  32'(bus.ctrl_id_ex_o),  32'(e_ie));
        chk({tag, ".ex_mem"}, 32'(bus.ctrl_ex_mem_o), 32'(e_em));
        chk({tag, ".mem_wb"}, 32'(bus.ctrl_mem_wb_o), 32'(e_mw));
        chk({tag, ".pc_wen"}, 32'(bus.pc_wen_o),      32'(e_pcw));
        chk({tag, ".redir"},  32'(bus.redirect_o),    32'(e_rdr));
    endtask

    task automatic idle();
        bus.id_rs1_addr_i     = 5'd0;
        bus.id_rs2_addr_i     = 5'd0;
        bus.id_rs1_ren_i      = 1'b0;
        bus.id_rs2_ren_i      = 1'b0;
        bus.ex_rd_addr_i      = 5'd0;
        bus.ex_wreg_i         = 1'b0;
        bus.ex_load_i         = 1'b0;
        bus.ex_branch_taken_i = 1'b0;
        bus.mem_req_i         = 1'b0;
        bus.mem_ready_i       = 1'b0;
    endtask

    task automatic load_ex(input logic [4:0] rd, input logic [4:0] rs1, input logic r1en,
                           input logic [4:0] rs2, input logic r2en);
        bus.ex_load_i     = 1'b1;
        bus.ex_wreg_i     = 1'b1;
        bus.ex_rd_addr_i  = rd;
        bus.id_rs1_addr_i = rs1;
        bus.id_rs1_ren_i  = r1en;
        bus.id_rs2_addr_i = rs2;
        bus.id_rs2_ren_i  = r2en;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(); rst = 1'b0; idle();
        tick(); rst = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle();

        // Reset values.
        tick(); tick(); #2;
        chk_outs("rst", U, U, U, U, 1'b0, 1'b0);
        chk("rst.cnt", 32'(bus.stall_cycles_o), 32'd0);
        tick(); rst = 1'b1; #2;
        chk_outs("run0", D, D, D, D, 1'b1, 1'b0);

        // Load-use: ld x5 in EX, add x6,x5,x7 in ID.
        tick(); load_ex(5'd5, 5'd5, 1'b1, 5'd7, 1'b1); #2;
        chk_outs("lu", K, U, D, D, 1'b0, 1'b0);
        tick(); idle(); #2;
        chk_outs("lu.next", D, D, D, D, 1'b1, 1'b0);
        chk("lu.cnt", 32'(bus.stall_cycles_o), 32'd1);
        tick(); load_ex(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); #2;
        chk_outs("lu.x0", D, D, D, D, 1'b1, 1'b0);
        tick(); load_ex(5'd9, 5'd9, 1'b0, 5'd9, 1'b1); #2;
        chk_outs("lu.rs2", K, U, D, D, 1'b0, 1'b0);
        tick(); load_ex(5'd9, 5'd9, 1'b0, 5'd3, 1'b1); #2;
        chk_outs("lu.noren", D, D, D, D, 1'b1, 1'b0);
        chk("lu.cnt2", 32'(bus.stall_cycles_o), 32'd2);

        // Branch with a two-cycle tail.
        tick(); idle(); bus.ex_branch_taken_i = 1'b1; #2;
        chk_outs("br0", U, U, D, D, 1'b1, 1'b1);
        tick(); idle(); #2;
        chk_outs("br1", U, D, D, D, 1'b1, 1'b0);
        tick(); #2;
        chk_outs("br2", U, D, D, D, 1'b1, 1'b0);
        tick(); #2;
        chk_outs("br3", D, D, D, D, 1'b1, 1'b0);

        // Memory wait of four cycles.
        do_reset();
        idle(); bus.mem_req_i = 1'b1; #2;
        chk_outs("mw0", K, K, K, U, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            tick(); idle(); #2;
            chk_outs($sformatf("mw%0d", i), K, K, K, U, 1'b0, 1'b0);
        end
        tick(); bus.mem_ready_i = 1'b1; #2;
        chk_outs("mw.rdy", D, D, D, D, 1'b1, 1'b0);
        chk("mw.cnt", 32'(bus.stall_cycles_o), 32'd4);
        tick(); idle(); bus.mem_req_i = 1'b1; bus.mem_ready_i = 1'b1; #2;
        chk_outs("mw.same", D, D, D, D, 1'b1, 1'b0);
        tick(); idle(); #2;
        chk_outs("mw.same1", D, D, D, D, 1'b1, 1'b0);
        chk("mw.samecnt", 32'(bus.stall_cycles_o), 32'd4);

        // Memory stall with a branch held in EX.
        tick(); bus.mem_req_i = 1'b1; bus.ex_branch_taken_i = 1'b1; #2;
        chk_outs("mb0", K, K, K, U, 1'b0, 1'b0);
        tick(); bus.mem_req_i = 1'b0; #2;
        chk_outs("mb1", K, K, K, U, 1'b0, 1'b0);
        tick(); bus.mem_ready_i = 1'b1; #2;
        chk_outs("mb.rdy", U, U, D, D, 1'b1, 1'b1);
        tick(); idle(); #2;
        chk_outs("mb.t1", U, D, D, D, 1'b1, 1'b0);
        tick(); #2;
        chk_outs("mb.t2", U, D, D, D, 1'b1, 1'b0);
        tick(); #2;
        chk_outs("mb.run", D, D, D, D, 1'b1, 1'b0);
        chk("mb.cnt", 32'(bus.stall_cycles_o), 32'd6);

        // Memory stall arriving with one tail cycle left.
        tick(); bus.ex_branch_taken_i = 1'b1; #2;
        chk_outs("fm0", U, U, D, D, 1'b1, 1'b1);
        tick(); idle(); #2;
        chk_outs("fm1", U, D, D, D, 1'b1, 1'b0);
        tick(); bus.mem_req_i = 1'b1; #2;
        chk_outs("fm.stall", K, K, K, U, 1'b0, 1'b0);
        tick(); idle(); bus.mem_ready_i = 1'b1; #2;
        chk_outs("fm.rdy", D, D, D, D, 1'b1, 1'b0);
        tick(); idle(); #2;
        chk_outs("fm.tail", U, D, D, D, 1'b1, 1'b0);
        tick(); #2;
        chk_outs("fm.run", D, D, D, D, 1'b1, 1'b0);
        chk("fm.cnt", 32'(bus.stall_cycles_o), 32'd7);

        // Reset asserted in the middle of a memory wait.
        tick(); bus.mem_req_i = 1'b1; #2;
        tick(); idle(); #2;
        chk_outs("rw.stall", K, K, K, U, 1'b0, 1'b0);
        rst = 1'b0; #1;
        chk_outs("rw.rst", U, U, U, U, 1'b0, 1'b0);
        chk("rw.cnt", 32'(bus.stall_cycles_o), 32'd0);
        tick(); rst = 1'b1; idle(); #2;
        chk_outs("rw.run", D, D, D, D, 1'b1, 1'b0);
        tick(); bus.mem_ready_i = 1'b1; #2;
        chk_outs("rw.rdyonly", D, D, D, D, 1'b1, 1'b0);

        // Saturation: 20 stall cycles into a 4-bit counter.
        tick(); idle(); bus.mem_req_i = 1'b1; #2;
        for (int i = 1; i < 20; i++) begin
            tick(); idle(); #2;
        end
        chk("sat.pre", 32'(bus.stall_cycles_o), 32'd15);
        tick(); bus.mem_ready_i = 1'b1; #2;
        chk("sat.cnt", 32'(bus.stall_cycles_o), 32'd15);
        tick(); idle(); #2;
        chk("sat.hold", 32'(bus.stall_cycles_o), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
